ptw_req_sched: RTL
==================

// Module: ptw_req_sched
// PURPOSE
//  Shares one sync_fifo page-walk request queue between the I-TLB and D-TLB miss ports.
//  Push side: round-robin arbiter. Pop side: one-walk-at-a-time FSM issuing to the PTW.
//  Routes each PTW response back to its originating TLB. Supports flush (sfence.vma) drain.
// PARAMETERS
//  VPN_WIDTH   20  virtual page number width
//  PPN_WIDTH   22  physical page number width
//  FIFO_WIDTH  VPN_WIDTH+1  queue entry {src,vpn}; src 0=ITLB, 1=DTLB
// PORTS
//  i_clk           in   1          clock, all state on posedge
//  i_rstn          in   1          async active-low reset
//  itlb_req_valid  in   1          I-TLB miss request
//  itlb_req_vpn    in   VPN_WIDTH  I-TLB miss VPN
//  itlb_req_ready  out  1          I-TLB request accepted this cycle (comb)
//  dtlb_req_valid  in   1          D-TLB miss request
//  dtlb_req_vpn    in   VPN_WIDTH  D-TLB miss VPN
//  dtlb_req_ready  out  1          D-TLB request accepted this cycle (comb)
//  fifo_push       out  1          queue push strobe (comb)
//  fifo_push_data  out  FIFO_WIDTH {src,vpn} of granted request
//  fifo_full       in   1          queue full
//  fifo_pop        out  1          queue pop strobe (comb)
//  fifo_pop_data   in   FIFO_WIDTH head entry, valid while !fifo_empty (fall-through)
//  fifo_empty      in   1          queue empty
//  ptw_req_valid   out  1          walk request to PTW (reg)
//  ptw_req_vpn     out  VPN_WIDTH  walk VPN (reg)
//  ptw_req_ready   in   1          PTW accepts request
//  ptw_resp_valid  in   1          PTW walk done, 1-cycle pulse
//  ptw_resp_ppn    in   PPN_WIDTH  resulting PPN
//  ptw_resp_fault  in   1          page fault
//  itlb_resp_valid out  1          1-cycle pulse to I-TLB (reg)
//  dtlb_resp_valid out  1          1-cycle pulse to D-TLB (reg)
//  resp_ppn        out  PPN_WIDTH  registered PPN, valid with either resp_valid
//  resp_fault      out  1          registered fault, valid with either resp_valid
//  flush           in   1          level; drop queued and in-flight walks
//  flush_busy      out  1          high while flush draining (comb)
// BEHAVIOUR
//  Reset: FSM=IDLE, last_grant=DTLB (ITLB wins first tie). All reg outputs 0; cur_src/cur_vpn/drop=0.
//  Arbiter (comb): one valid -> granted; both -> the one != last_grant.
//   ready_x = grant_x & !fifo_full & !flush; fifo_push = |ready. push_data = {src,vpn} of grant.
//   last_grant updates only on an accepted push.
//  Pop FSM:
//   IDLE: if !fifo_empty: fifo_pop=1; latch src/vpn from fifo_pop_data.
//    If flush: discard, stay IDLE. Else -> ISSUE with ptw_req_valid=1.
//   ISSUE: hold ptw_req_valid/vpn stable until ptw_req_ready; then valid=0 -> WAIT.
//    Request never retracted, even under flush.
//   WAIT: on ptw_resp_valid: if !drop, pulse resp_valid of cur_src next cycle with ppn/fault.
//    Clear drop -> IDLE.
//  flush in ISSUE/WAIT sets drop; response for that walk is swallowed.
//  flush_busy = flush & (!fifo_empty | state!=IDLE). Pops one entry/cycle while flush.
//  Latency: push in cycle N -> earliest ptw_req_valid in cycle N+2 (FIFO write, pop/latch).
//   ptw_resp_valid in cycle M -> x_resp_valid in cycle M+1.
//  Simultaneous push & pop on same cycle: legal, independent.
//  fifo_full: both readies 0, requests held by TLBs. ptw_resp_valid outside WAIT: ignored.
//  Async reset mid-walk: FSM to IDLE, in-flight walk forgotten; PTW also reset.
// TESTING
//  1. Reset, ITLB req vpn=0x12345 -> push {0,0x12345}; ptw_req_valid at +2 cycles.
//     Resp ppn=0x3ABCD fault=0 -> itlb_resp_valid 1 cycle later, resp_ppn=0x3ABCD.
//  2. ITLB and DTLB valid for 4 cycles -> pushes alternate I,D,I,D; responses route to matching TLB.
//  3. Fill FIFO to 16 entries -> readies 0; one pop -> exactly one more push accepted.
//  4. ptw_req_ready low 5 cycles in ISSUE -> valid/vpn stable, no further pop until WAIT done.
//  5. 3 queued + flush during WAIT -> 3 pops over 3 cycles.
//     In-flight resp swallowed (no resp_valid); flush_busy clears at IDLE & empty.
//  6. Reset asserted in WAIT -> state IDLE, all outputs 0; later resp_valid ignored.
//  7. DTLB fault walk: resp_fault=1 -> dtlb_resp_valid pulse with resp_fault=1; itlb_resp_valid stays 0.

Source files
------------

// File: rtl/ptw_req_sched.sv
// ptw_req_sched: shares one page-walk request queue between I-TLB and D-TLB and runs one walk at a time
// Ports:
//   i_clk, i_rstn                      clock, async active-low reset
//   itlb_req_*, dtlb_req_*             TLB miss requests (valid/vpn in, ready out)
//   fifo_push/_data, fifo_full         queue write side, round-robin granted {src,vpn}
//   fifo_pop, fifo_pop_data, fifo_empty queue read side, fall-through head
//   ptw_req_*                          walk request to the PTW (valid/vpn held until ready)
//   ptw_resp_*                         walk completion pulse with ppn/fault
//   itlb_resp_valid, dtlb_resp_valid   response pulse routed to the originating TLB
//   resp_ppn, resp_fault               registered walk result
//   flush, flush_busy                  drop queued and in-flight walks, drain status
module ptw_req_sched #(
  parameter int VPN_WIDTH  = 20,
  parameter int PPN_WIDTH  = 22,
  parameter int FIFO_WIDTH = VPN_WIDTH + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  itlb_req_valid,
  input  logic [VPN_WIDTH-1:0]  itlb_req_vpn,
  output logic                  itlb_req_ready,
  input  logic                  dtlb_req_valid,
  input  logic [VPN_WIDTH-1:0]  dtlb_req_vpn,
  output logic                  dtlb_req_ready,
  output logic                  fifo_push,
  output logic [FIFO_WIDTH-1:0] fifo_push_data,
  input  logic                  fifo_full,
  output logic                  fifo_pop,
  input  logic [FIFO_WIDTH-1:0] fifo_pop_data,
  input  logic                  fifo_empty,
  output logic                  ptw_req_valid,
  output logic [VPN_WIDTH-1:0]  ptw_req_vpn,
  input  logic                  ptw_req_ready,
  input  logic                  ptw_resp_valid,
  input  logic [PPN_WIDTH-1:0]  ptw_resp_ppn,
  input  logic                  ptw_resp_fault,
  output logic                  itlb_resp_valid,
  output logic                  dtlb_resp_valid,
  output logic [PPN_WIDTH-1:0]  resp_ppn,
  output logic                  resp_fault,
  input  logic                  flush,
  output logic                  flush_busy
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t r_state, w_next;
  logic r_last_grant, r_cur_src, r_drop;
  logic w_gnt_d, w_gnt_i, w_acc, w_start, w_done, w_emit;
  // on a tie the source that did not win last time is granted
  assign w_gnt_d = dtlb_req_valid & (~itlb_req_valid | ~r_last_grant);
  assign w_gnt_i = itlb_req_valid & ~w_gnt_d;
  assign w_acc = ~fifo_full & ~flush;
  assign itlb_req_ready = w_gnt_i & w_acc;
  assign dtlb_req_ready = w_gnt_d & w_acc;
  assign fifo_push = itlb_req_ready | dtlb_req_ready;
  assign fifo_push_data = {w_gnt_d, w_gnt_d ? dtlb_req_vpn : itlb_req_vpn};
  assign flush_busy = flush & (~fifo_empty | r_state != S_IDLE);
  assign w_start = r_state == S_IDLE & ~fifo_empty & ~flush;
  assign w_done = r_state == S_WAIT & ptw_resp_valid;
  // a flush arriving together with the response also swallows it
  assign w_emit = w_done & ~r_drop & ~flush;
  always_comb begin
    w_next = r_state;
    fifo_pop = 1'b0;
    case (r_state)
      S_IDLE: begin
        fifo_pop = ~fifo_empty;
        w_next = w_start ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: w_next = ptw_req_ready ? S_WAIT : S_ISSUE;
      S_WAIT: w_next = ptw_resp_valid ? S_IDLE : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
      r_last_grant <= 1'b1;
      r_cur_src <= 1'b0;
      r_drop <= 1'b0;
      ptw_req_valid <= 1'b0;
      ptw_req_vpn <= '0;
      itlb_resp_valid <= 1'b0;
      dtlb_resp_valid <= 1'b0;
      resp_ppn <= '0;
      resp_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (fifo_push) r_last_grant <= w_gnt_d;
      if (w_start) begin
        r_cur_src <= fifo_pop_data[FIFO_WIDTH-1];
        ptw_req_vpn <= fifo_pop_data[VPN_WIDTH-1:0];
        ptw_req_valid <= 1'b1;
      end else if (r_state == S_ISSUE && ptw_req_ready) begin
        ptw_req_valid <= 1'b0;
      end
      r_drop <= w_done ? 1'b0 : r_drop | (flush & r_state != S_IDLE);
      itlb_resp_valid <= w_emit & ~r_cur_src;
      dtlb_resp_valid <= w_emit & r_cur_src;
      if (w_emit) begin
        resp_ppn <= ptw_resp_ppn;
        resp_fault <= ptw_resp_fault;
      end
    end
  end
endmodule
